selector_juego_param: RTL and testbench
=======================================

Name: selector_juego_param

Overview:
- Parametrised successor of the fixed 6-game mode selector for the AY-3-8500 pong core on ZXDOS.
- Selects 1 of NUM_GAMES games from three sources: a one-hot direct-select bus and next/prev buttons.
- Synchronises and debounces all inputs and drives active-low one-hot game lines (0 = selected) into the game core.
- On every accepted game change it issues a timed reset pulse to the game core, which the fixed selector never did.

Parameters:
- NUM_GAMES, 7, number of games; 2..16.
- DEFAULT_GAME, 0, index selected after reset; 0..NUM_GAMES-1.
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles needed to accept a level change; >=1.
- RESET_PULSE_CYCLES, 64, length of o_chip_reset after a change; >=1.
- WRAP, 1, 1 = next/prev wrap around the ends; 0 = saturate at the ends.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- i_gamesel, input, NUM_GAMES: direct select, one-hot, active-high, level.
- i_next, input, 1: next-game button, active-high.
- i_prev, input, 1: previous-game button, active-high.
- i_lock, input, 1: game in progress; all requests are ignored while high.
- o_game_n, output, NUM_GAMES: active-low one-hot selection to the game core.
- o_game_idx, output, $clog2(NUM_GAMES): binary index of the current game.
- o_changed, output, 1: one-cycle pulse when the selection changes.
- o_chip_reset, output, 1: active-high reset to the game core.

Behaviour:
- Reset (asynchronous, while reset is high):
  - idx = DEFAULT_GAME; o_game_n = ~(1<<DEFAULT_GAME); o_changed = 0; o_chip_reset = 1.
  - Synchronisers, debounced levels and counters all clear to 0.
  - FSM enters HOLD with the counter at 0, so the core receives a full RESET_PULSE_CYCLES pulse after reset deasserts.
- Input conditioning, applied per bit to i_gamesel, i_next, i_prev and i_lock:
  - 2-FF synchroniser.
  - Debouncer: a counter runs while the synced level differs from the debounced level and clears whenever they match.
  - The debounced level flips on the edge where the count reaches DEBOUNCE_CYCLES.
- Latency: an input changing before edge 0 updates its debounced level at edge 1+DEBOUNCE_CYCLES.
- Request evaluation (combinational, valid only in IDLE with debounced lock = 0), in priority order:
  1. Direct select: debounced i_gamesel is exactly one-hot and its index differs from idx.
     - All-zero or multi-hot bus → no request.
  2. Rising edge of debounced next, with debounced prev low → target idx+1.
     - At NUM_GAMES-1: WRAP=1 gives 0; WRAP=0 gives no request.
  3. Rising edge of debounced prev, with debounced next low → target idx-1.
     - At 0: WRAP=1 gives NUM_GAMES-1; WRAP=0 gives no request.
  - next and prev rising on the same cycle → no request.
  - Target equal to idx → no request, no pulse.
- FSM states:
  - IDLE: on a request, at the next edge:
    - idx and o_game_n take the target;
    - o_changed = 1 for exactly that cycle;
    - o_chip_reset goes to 1;
    - FSM enters HOLD with the counter at 0.
  - HOLD: o_chip_reset = 1; the counter increments each cycle.
    - After RESET_PULSE_CYCLES cycles high, o_chip_reset = 0 and the FSM returns to IDLE.
- Dropped requests (not queued):
  - Requests are ignored while in HOLD.
  - Edges that occur during HOLD or while locked are lost.
  - A one-hot i_gamesel still held at the return to IDLE is honoured, because it is level-based.
- Lock: debounced lock going high mid-HOLD does not cut the pulse short.
- Reset mid-HOLD: returns to the reset state and restarts the full pulse.
- Output invariant: o_game_n always has exactly one 0 bit, and that bit equals o_game_idx. No Z or X values are ever driven.
- All outputs are registered.

Test Plan (NUM_GAMES=7, DEBOUNCE_CYCLES=4, RESET_PULSE_CYCLES=8, DEFAULT_GAME=0, WRAP=1 unless stated):
- Release reset → o_game_n=7'b1111110, o_game_idx=0, o_chip_reset high for exactly 8 cycles then low, o_changed never pulses.
- i_gamesel=7'b0000100 held from edge 0 → at edge 6: o_game_idx=2, o_game_n=7'b1111011, o_changed single pulse, o_chip_reset high 8 cycles.
- i_gamesel glitch lasting 3 cycles → no change; i_gamesel=7'b0000110 held → no change.
- idx=6, one i_next press → idx=0; WRAP=0 rerun with idx=6 → stays 6, no pulse; idx=0 with i_prev → idx=6 (WRAP=1).
- i_lock high, then i_next press and i_gamesel=7'b0001000 → no change; release i_lock with i_gamesel still held → idx=3 after debounce.
- i_next pressed during HOLD → ignored; assert reset mid-HOLD → idx=0, full 8-cycle pulse restarts; i_next and i_prev rising together → no change.

Source files
------------

// File: rtl/selector_juego_param.sv
// selector_juego_param: parametrised game selector for the AY-3-8500 pong core.
// Conditions direct-select and next/prev inputs, keeps the current game index,
// drives active-low one-hot game lines and issues a timed reset pulse to the
// game core on every accepted change.
module selector_juego_param #(
    parameter int NUM_GAMES          = 7,
    parameter int DEFAULT_GAME       = 0,
    parameter int DEBOUNCE_CYCLES    = 50000,
    parameter int RESET_PULSE_CYCLES = 64,
    parameter int WRAP               = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_GAMES-1:0]         i_gamesel,
    input  logic                         i_next,
    input  logic                         i_prev,
    input  logic                         i_lock,
    output logic [NUM_GAMES-1:0]         o_game_n,
    output logic [$clog2(NUM_GAMES)-1:0] o_game_idx,
    output logic                         o_changed,
    output logic                         o_chip_reset
);

    localparam int IW = $clog2(NUM_GAMES);
    localparam int NI = NUM_GAMES + 3;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(RESET_PULSE_CYCLES + 1);

    typedef enum logic {IDLE, HOLD} state_t;

    logic [NI-1:0]        raw, s1, s2, deb;
    logic [CW-1:0]        db_cnt [NI];
    logic [NUM_GAMES-1:0] deb_sel;
    logic                 deb_next, deb_prev, deb_lock;
    logic                 next_d, prev_d, rise_next, rise_prev;

    state_t               state, state_nxt;
    logic [HW-1:0]        hold_cnt, cnt_nxt;
    logic [IW-1:0]        idx, idx_nxt, tgt, sel_idx;
    logic [4:0]           pop;
    logic                 req;
    logic                 changed_nxt, chip_reset_nxt;
    logic [NUM_GAMES-1:0] game_n_nxt;

    assign raw = {i_lock, i_prev, i_next, i_gamesel};

    // Two-flop synchroniser for every conditioned input bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Per-bit debouncer: count while synced level differs, flip when count reaches limit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb <= '0;
            for (int unsigned i = 0; i < NI; i++) db_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NI; i++) begin
                if (s2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    deb[i]    <= s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign deb_sel  = deb[NUM_GAMES-1:0];
    assign deb_next = deb[NUM_GAMES];
    assign deb_prev = deb[NUM_GAMES+1];
    assign deb_lock = deb[NUM_GAMES+2];

    // Previous debounced button levels; tracked in every state so edges seen while busy are lost
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            next_d <= 1'b0;
            prev_d <= 1'b0;
        end else begin
            next_d <= deb_next;
            prev_d <= deb_prev;
        end
    end

    assign rise_next = deb_next & ~next_d;
    assign rise_prev = deb_prev & ~prev_d;

    // Request evaluation: direct select, then next, then prev
    always_comb begin
        pop     = '0;
        sel_idx = '0;
        req     = 1'b0;
        tgt     = idx;
        for (int unsigned i = 0; i < NUM_GAMES; i++) begin
            if (deb_sel[i]) begin
                pop     = pop + 1'b1;
                sel_idx = IW'(i);
            end
        end
        if (state == IDLE && !deb_lock) begin
            if (pop == 5'd1 && sel_idx != idx) begin
                req = 1'b1;
                tgt = sel_idx;
            end else if (rise_next && !deb_prev) begin
                if (idx == IW'(NUM_GAMES - 1)) begin
                    if (WRAP != 0) begin
                        req = 1'b1;
                        tgt = '0;
                    end
                end else begin
                    req = 1'b1;
                    tgt = idx + 1'b1;
                end
            end else if (rise_prev && !deb_next) begin
                if (idx == '0) begin
                    if (WRAP != 0) begin
                        req = 1'b1;
                        tgt = IW'(NUM_GAMES - 1);
                    end
                end else begin
                    req = 1'b1;
                    tgt = idx - 1'b1;
                end
            end
        end
    end

    // State register together with the registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= HOLD;
            hold_cnt     <= '0;
            idx          <= IW'(DEFAULT_GAME);
            o_game_n     <= ~(NUM_GAMES'(1) << DEFAULT_GAME);
            o_changed    <= 1'b0;
            o_chip_reset <= 1'b1;
        end else begin
            state        <= state_nxt;
            hold_cnt     <= cnt_nxt;
            idx          <= idx_nxt;
            o_game_n     <= game_n_nxt;
            o_changed    <= changed_nxt;
            o_chip_reset <= chip_reset_nxt;
        end
    end

    // Next-state logic: accept a request in IDLE, time the pulse in HOLD
    always_comb begin
        state_nxt = state;
        cnt_nxt   = hold_cnt;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                    idx_nxt   = tgt;
                end
            end
            HOLD: begin
                if (hold_cnt == HW'(RESET_PULSE_CYCLES - 1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        changed_nxt    = (state == IDLE) && req;
        chip_reset_nxt = (state_nxt == HOLD);
        game_n_nxt     = ~(NUM_GAMES'(1) << idx_nxt);
    end

    assign o_game_idx = idx;

endmodule

// File: tb/tb_selector_juego_param.sv
// Testbench for selector_juego_param: table-driven vectors plus hand sequences
// for reset pulse length, glitch rejection, HOLD-time presses and reset mid-HOLD.
module tb_selector_juego_param;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] gamesel;
    logic       nxt, prv, lck;

    logic [6:0] game_n_a, game_n_b;
    logic [2:0] idx_a, idx_b;
    logic       chg_a, chg_b, crst_a, crst_b;

    int n_chk = 0;
    int n_bad = 0;
    int p_a, p_b;

    typedef struct {
        logic [6:0] sel;
        logic       n;
        logic       p;
        logic       l;
        int         e_idx;
        int         e_nw;
        int         e_pa;
        int         e_pb;
    } vec_t;

    vec_t tbl [20];

    selector_juego_param #(.NUM_GAMES(7), .DEFAULT_GAME(0), .DEBOUNCE_CYCLES(4),
                           .RESET_PULSE_CYCLES(8), .WRAP(1)) dut (
        .clk(clk), .reset(reset), .i_gamesel(gamesel), .i_next(nxt), .i_prev(prv),
        .i_lock(lck), .o_game_n(game_n_a), .o_game_idx(idx_a), .o_changed(chg_a),
        .o_chip_reset(crst_a));

    selector_juego_param #(.NUM_GAMES(7), .DEFAULT_GAME(0), .DEBOUNCE_CYCLES(4),
                           .RESET_PULSE_CYCLES(8), .WRAP(0)) dut_nw (
        .clk(clk), .reset(reset), .i_gamesel(gamesel), .i_next(nxt), .i_prev(prv),
        .i_lock(lck), .o_game_n(game_n_b), .o_game_idx(idx_b), .o_changed(chg_b),
        .o_chip_reset(crst_b));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run n cycles, counting o_changed pulses of both instances
    task automatic run(input int n);
        p_a = 0;
        p_b = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (chg_a) p_a++;
            if (chg_b) p_b++;
        end
    endtask

    task automatic wait_changed(input string name);
        int found;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (chg_a) begin
                found = 1;
                break;
            end
        end
        chk(name, found, 1);
    endtask

    // Count cycles of chip reset high and change pulses over a window after reset release
    task automatic count_pulse(input string name);
        int hi, ch;
        hi = 0;
        ch = 0;
        for (int i = 0; i < 30; i++) begin
            if (crst_a) hi++;
            if (chg_a) ch++;
            tick();
        end
        chk({name, "_pulse_len"}, hi, 8);
        chk({name, "_changed"}, ch, 0);
    endtask

    function automatic int gn(input int i);
        logic [6:0] v;
        v = 7'h7f;
        v[i] = 1'b0;
        return int'(v);
    endfunction

    initial begin
        tbl[0]  = '{7'b0000100, 0, 0, 0, 2, 2, 1, 1};
        tbl[1]  = '{7'b0000000, 0, 0, 0, 2, 2, 0, 0};
        tbl[2]  = '{7'b0000110, 0, 0, 0, 2, 2, 0, 0};
        tbl[3]  = '{7'b0000000, 0, 0, 0, 2, 2, 0, 0};
        tbl[4]  = '{7'b1000000, 0, 0, 0, 6, 6, 1, 1};
        tbl[5]  = '{7'b0000000, 0, 0, 0, 6, 6, 0, 0};
        tbl[6]  = '{7'b0000000, 1, 0, 0, 0, 6, 1, 0};
        tbl[7]  = '{7'b0000000, 0, 0, 0, 0, 6, 0, 0};
        tbl[8]  = '{7'b0000000, 0, 1, 0, 6, 5, 1, 1};
        tbl[9]  = '{7'b0000000, 0, 0, 0, 6, 5, 0, 0};
        tbl[10] = '{7'b0000001, 0, 0, 0, 0, 0, 1, 1};
        tbl[11] = '{7'b0000000, 0, 0, 0, 0, 0, 0, 0};
        tbl[12] = '{7'b0000000, 0, 1, 0, 6, 0, 1, 0};
        tbl[13] = '{7'b0000000, 0, 0, 0, 6, 0, 0, 0};
        tbl[14] = '{7'b0000000, 1, 0, 0, 0, 1, 1, 1};
        tbl[15] = '{7'b0000000, 0, 0, 0, 0, 1, 0, 0};
        tbl[16] = '{7'b0000000, 0, 0, 1, 0, 1, 0, 0};
        tbl[17] = '{7'b0001000, 1, 0, 1, 0, 1, 0, 0};
        tbl[18] = '{7'b0001000, 1, 0, 0, 3, 3, 1, 1};
        tbl[19] = '{7'b0000000, 0, 0, 0, 3, 3, 0, 0};

        reset   = 1'b1;
        gamesel = '0;
        nxt     = 1'b0;
        prv     = 1'b0;
        lck     = 1'b0;
        tick();
        tick();
        chk("rst_idx", int'(idx_a), 0);
        chk("rst_game_n", int'(game_n_a), gn(0));
        chk("rst_chip_reset", int'(crst_a), 1);
        chk("rst_changed", int'(chg_a), 0);
        reset = 1'b0;
        count_pulse("por");
        chk("por_idx", int'(idx_a), 0);

        // Glitch shorter than the debounce window must be rejected
        gamesel = 7'b0000010;
        tick();
        tick();
        tick();
        gamesel = '0;
        run(20);
        chk("glitch_idx", int'(idx_a), 0);
        chk("glitch_pulses", p_a, 0);

        for (int v = 0; v < 20; v++) begin
            gamesel = tbl[v].sel;
            nxt     = tbl[v].n;
            prv     = tbl[v].p;
            lck     = tbl[v].l;
            run(24);
            chk($sformatf("v%0d_idx", v), int'(idx_a), tbl[v].e_idx);
            chk($sformatf("v%0d_game_n", v), int'(game_n_a), gn(tbl[v].e_idx));
            chk($sformatf("v%0d_pulses", v), p_a, tbl[v].e_pa);
            chk($sformatf("v%0d_nw_idx", v), int'(idx_b), tbl[v].e_nw);
            chk($sformatf("v%0d_nw_game_n", v), int'(game_n_b), gn(tbl[v].e_nw));
            chk($sformatf("v%0d_nw_pulses", v), p_b, tbl[v].e_pb);
            chk($sformatf("v%0d_chip_reset", v), int'(crst_a), 0);
        end

        // next pressed during HOLD is lost
        gamesel = 7'b0000010;
        wait_changed("hold_wait");
        chk("hold_chip_reset", int'(crst_a), 1);
        gamesel = '0;
        nxt     = 1'b1;
        run(24);
        chk("hold_next_idx", int'(idx_a), 1);
        chk("hold_next_pulses", p_a, 0);
        nxt = 1'b0;
        run(24);
        chk("hold_rel_idx", int'(idx_a), 1);

        // Reset in the middle of HOLD restarts the full pulse
        gamesel = 7'b0100000;
        wait_changed("midrst_wait");
        chk("midrst_pre_idx", int'(idx_a), 5);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("midrst_idx", int'(idx_a), 0);
        chk("midrst_game_n", int'(game_n_a), gn(0));
        chk("midrst_chip_reset", int'(crst_a), 1);
        gamesel = '0;
        tick();
        reset = 1'b0;
        count_pulse("midrst");
        chk("midrst_post_idx", int'(idx_a), 0);

        // next and prev rising together cancel out
        nxt = 1'b1;
        prv = 1'b1;
        run(24);
        chk("both_idx", int'(idx_a), 0);
        chk("both_pulses", p_a, 0);
        nxt = 1'b0;
        prv = 1'b0;
        run(24);
        chk("both_rel_idx", int'(idx_a), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end

endmodule
